fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage that sits directly downstream of the synchronous program ROM. It drives the ROM address, absorbs the ROM's one-cycle registered read latency, decodes 6502 instruction length from the opcode, and assembles opcode plus 0–2 operand bytes into one instruction word. The word is presented to the core's decode stage over a valid/ready handshake. It also accepts a redirect (jump/branch) from the core.

## Interface
Parameters:
- ADDR_WIDTH, 6, width of the ROM address and program counter (ROM depth = 2^ADDR_WIDTH bytes)
- RESET_PC, 0, program counter value loaded on reset

Ports:
- raw_clk  input  1  sole clock. Rising-edge; same clock as the ROM.
- reset_n  input  1  asynchronous, active-low reset
- rom_address  output  ADDR_WIDTH  byte address to ROM; combinationally equal to internal pc
- rom_data  input  8  ROM read data; valid the cycle after the ROM samples rom_address
- jump  input  1  one-cycle redirect request
- jump_address  input  ADDR_WIDTH  redirect target, sampled when jump=1
- insn_valid  output  1  assembled instruction available
- insn_ready  input  1  core accepts instruction when insn_valid & insn_ready
- opcode  output  8  first byte of instruction
- operand  output  16  byte 1 in [7:0], byte 2 in [15:8]; unused bytes read 0
- insn_length  output  2  1, 2 or 3
- insn_pc  output  ADDR_WIDTH  address of the opcode byte

## Operation
- States: READ, CAPTURE, VALID.
  - READ: ROM samples pc at the end of the cycle; go to CAPTURE.
  - CAPTURE: rom_data holds byte[pc].
    - Store rom_data into slot k (0 = opcode, 1, 2) and increment pc.
    - k=0: also record insn_pc = pc, compute length, clear operand.
    - Go to VALID when k = length−1; otherwise go to READ with k+1.
  - VALID: insn_valid=1; outputs held stable. On insn_ready, go to READ with k=0.
- Length decode, with aaa=op[7:5], bbb=op[4:2], cc=op[1:0]:
  - Length 3: op=0x20, or bbb∈{011,111}, or (cc=01 and bbb=110).
  - Length 1 (otherwise): op∈{0x00,0x40,0x60}, or (cc≠01 and bbb∈{010,110}), or cc=11.
  - Else length 2.
  - Rules are evaluated in the order listed.
- pc arithmetic is modulo 2^ADDR_WIDTH. An instruction whose operand bytes cross the top of ROM continues from address 0.
- Jump in any state:
  - pc ← jump_address, k ← 0, next state READ, insn_valid deasserts next cycle.
  - Any partial instruction is discarded.
  - If jump coincides with a VALID handshake, the instruction counts as consumed; the jump target is fetched next.
  - Jump during CAPTURE overrides the capture; no slot or pc update from that byte.
- Reset (asynchronous, any time including mid-instruction):
  - pc=RESET_PC, state=READ, k=0, insn_valid=0.
  - opcode=0, operand=0, insn_length=0, insn_pc=0.
  - rom_address therefore equals RESET_PC during reset.

## Timing
- Each byte costs 2 cycles (READ, CAPTURE).
- Counting the first cycle after reset_n rises as cycle 1, insn_valid asserts in cycle 2L+1 for a length-L instruction.
  - Length 1: cycle 3.
  - Length 3: cycle 7.
- After a handshake in cycle N: insn_valid=0 in cycle N+1 and the next fetch starts (READ) in cycle N+1. Next valid is in cycle N+1+2L.
- Jump asserted in cycle N:
  - rom_address = jump_address in cycle N+1.
  - insn_valid=0 in cycle N+1.
  - First instruction at the target is valid in cycle N+1+2L.
- insn_valid never drops without a handshake, jump or reset. opcode/operand/insn_length/insn_pc do not change while insn_valid=1.
- Throughput: no prefetch; at most one instruction per 2L+1 cycles.

## Test plan
- Reset and 1-byte fetch: ROM[0]=0xEA, insn_ready=1 → insn_valid in cycle 3 with opcode=0xEA, operand=0x0000, insn_length=1, insn_pc=0.
- Mixed lengths: ROM 0..5 = A9 05 8D 00 02 EA, ready tied high → three instructions in order:
  - (A9, 0x0005, 2, pc 0)
  - (8D, 0x0200, 3, pc 2)
  - (EA, 0x0000, 1, pc 5)
  - Valids in cycles 5, 12, 15.
- Backpressure: hold insn_ready=0 for 10 cycles at the first valid → outputs and rom_address unchanged throughout. After ready rises, the next instruction follows at the specified latency.
- Jump mid-fetch:
  - Assert jump with jump_address=0x10 during the CAPTURE of operand byte 1 of a 3-byte instruction.
  - Required: no valid for the partial instruction; rom_address=0x10 the next cycle; the instruction at 0x10 is delivered with insn_pc=0x10.
- Wrap-around: ADDR_WIDTH=6, ROM[63]=0x4C, ROM[0]=0x34, ROM[1]=0x12, jump to 63 → opcode=0x4C, operand=0x1234, insn_length=3, insn_pc=63. The next fetch is from address 2.
- Async reset mid-instruction: drop reset_n between clock edges during a 3-byte fetch → all outputs go to their reset values immediately, without waiting for a clock edge. After release, fetch restarts at RESET_PC.
- Simultaneous jump and handshake: jump with jump_address=0x20 in the same cycle as insn_valid & insn_ready → instruction consumed exactly once; next delivered insn_pc=0x20.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks the program ROM byte by byte, decodes 6502 instruction
// length from the opcode and presents opcode + operand bytes over a valid/ready handshake.
module fetch_unit #(
  parameter int unsigned            ADDR_WIDTH = 6,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  raw_clk,
  input  logic                  reset_n,
  output logic [ADDR_WIDTH-1:0] rom_address,
  input  logic [7:0]            rom_data,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_address,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [7:0]            opcode,
  output logic [15:0]           operand,
  output logic [1:0]            insn_length,
  output logic [ADDR_WIDTH-1:0] insn_pc
);

  typedef enum logic [1:0] {
    READ    = 2'd0,
    CAPTURE = 2'd1,
    VALID   = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [1:0]            k;
  logic [1:0]            len_now;
  logic [1:0]            cur_len;
  logic                  last_byte;

  function automatic logic [1:0] decode_length(input logic [7:0] op);
    logic [2:0] bbb;
    logic [1:0] cc;
    logic [1:0] len;
    bbb = op[4:2];
    cc  = op[1:0];
    if (op == 8'h20 || bbb == 3'b011 || bbb == 3'b111 || (cc == 2'b01 && bbb == 3'b110))
      len = 2'd3;
    else if (op == 8'h00 || op == 8'h40 || op == 8'h60 ||
             (cc != 2'b01 && (bbb == 3'b010 || bbb == 3'b110)) || cc == 2'b11)
      len = 2'd1;
    else
      len = 2'd2;
    return len;
  endfunction

  assign rom_address = pc;

  // The opcode byte decides the length in the same cycle it is captured, so the
  // end-of-instruction test uses the fresh decode for slot 0 and the stored length after.
  always_comb begin
    len_now   = decode_length(rom_data);
    cur_len   = (k == 2'd0) ? len_now : insn_length;
    last_byte = (k == cur_len - 2'd1);
  end

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= READ;
      pc          <= RESET_PC;
      k           <= '0;
      insn_valid  <= 1'b0;
      opcode      <= '0;
      operand     <= '0;
      insn_length <= '0;
      insn_pc     <= '0;
    end else if (jump) begin
      state      <= READ;
      pc         <= jump_address;
      k          <= '0;
      insn_valid <= 1'b0;
    end else begin
      case (state)
        READ: state <= CAPTURE;
        CAPTURE: begin
          pc <= pc + ADDR_WIDTH'(1);
          case (k)
            2'd0: begin
              opcode      <= rom_data;
              insn_pc     <= pc;
              insn_length <= len_now;
              operand     <= '0;
            end
            2'd1:    operand[7:0]  <= rom_data;
            default: operand[15:8] <= rom_data;
          endcase
          if (last_byte) begin
            state      <= VALID;
            insn_valid <= 1'b1;
          end else begin
            state <= READ;
            k     <= k + 2'd1;
          end
        end
        VALID: begin
          if (insn_ready) begin
            state      <= READ;
            k          <= '0;
            insn_valid <= 1'b0;
          end
        end
        default: state <= READ;
      endcase
    end
  end

endmodule
